// File: rtl/sum_block_if.sv
// sum_block_if: valid/ready bus for the block accumulator.
// The input side carries adder sums (in_valid, in_ready, in_sum).
// The output side carries the block total (out_valid, out_ready, out_total, out_overflow).
// Modport slave is the accumulator; modport master is the producer/consumer driving it.
interface sum_block_if #(
    parameter int DATA_W = 32,
    parameter int GUARD  = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_W-1:0]       in_sum;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_W+GUARD-1:0] out_total;
    logic                    out_overflow;

    modport slave (
        input  in_valid, in_sum, out_ready,
        output in_ready, out_valid, out_total, out_overflow
    );

    modport master (
        output in_valid, in_sum, out_ready,
        input  in_ready, out_valid, out_total, out_overflow
    );
endinterface

// File: rtl/sum_block_accumulator.sv
// sum_block_accumulator: sums blocks of COUNT adder results into a widened total with a sticky overflow flag.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset
//   clear - synchronous abort of the current block; it also drops out_valid
//   bus   - slave side of sum_block_if (input beats in, block total out)
module sum_block_accumulator #(
    parameter int DATA_W = 32,
    parameter int COUNT  = 4,
    parameter int GUARD  = 8
) (
    input logic        clk,
    input logic        rst,
    input logic        clear,
    sum_block_if.slave bus
);
    localparam int TW = DATA_W + GUARD;
    localparam int CW = COUNT > 1 ? $clog2(COUNT) : 1;

    typedef enum logic {ACC, HOLD} state_t;

    state_t        state;
    logic [TW-1:0] acc;
    logic [CW-1:0] cnt;
    logic          ovf;
    logic [TW:0]   sum;
    logic          last;

    // The extra top bit of sum is the carry out of the modular add.
    assign sum  = {1'b0, acc} + {{(GUARD + 1){1'b0}}, bus.in_sum};
    assign last = cnt == CW'(COUNT - 1);
    assign bus.in_ready = !rst && state == ACC && !clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ACC;
            acc              <= '0;
            cnt              <= '0;
            ovf              <= 1'b0;
            bus.out_valid    <= 1'b0;
            bus.out_total    <= '0;
            bus.out_overflow <= 1'b0;
        end else if (clear) begin
            state         <= ACC;
            acc           <= '0;
            cnt           <= '0;
            ovf           <= 1'b0;
            bus.out_valid <= 1'b0;
        end else if (state == ACC) begin
            // In ACC without clear, in_ready is high, so in_valid alone is an accepted beat.
            if (bus.in_valid) begin
                if (last) begin
                    bus.out_total    <= sum[TW-1:0];
                    bus.out_overflow <= ovf | sum[TW];
                    bus.out_valid    <= 1'b1;
                    state            <= HOLD;
                end
                acc <= sum[TW-1:0];
                ovf <= ovf | sum[TW];
                cnt <= last ? '0 : cnt + 1'b1;
            end
        end else if (bus.out_ready) begin
            state         <= ACC;
            acc           <= '0;
            cnt           <= '0;
            ovf           <= 1'b0;
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sum_block_accumulator.sv
// tb_sum_block_accumulator: checks a GUARD=8 and a GUARD=0 accumulator against a true-sum model.
module tb_sum_block_accumulator;
    logic        clk = 0;
    logic        rst = 1;
    logic        clear = 0;
    logic        in_valid = 0;
    logic        out_ready = 1;
    logic [31:0] in_sum = 0;
    int          checks = 0;
    int          errors = 0;

    sum_block_if #(.DATA_W(32), .GUARD(8)) bi ();
    sum_block_if #(.DATA_W(32), .GUARD(0)) bz ();

    assign bi.in_valid  = in_valid;
    assign bi.in_sum    = in_sum;
    assign bi.out_ready = out_ready;
    assign bz.in_valid  = in_valid;
    assign bz.in_sum    = in_sum;
    assign bz.out_ready = out_ready;

    sum_block_accumulator #(.DATA_W(32), .COUNT(4), .GUARD(8)) dut (
        .clk(clk), .rst(rst), .clear(clear), .bus(bi)
    );
    sum_block_accumulator #(.DATA_W(32), .COUNT(4), .GUARD(0)) dut0 (
        .clk(clk), .rst(rst), .clear(clear), .bus(bz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: keeps the exact (unbounded) block sum; the total is that sum modulo 2^TW
    // and overflow means the exact sum reached 2^TW.
    logic [63:0] lim [2];
    logic        hold[2];
    logic [63:0] tot [2];
    int          n   [2];
    logic        ev  [2];
    logic [63:0] et  [2];
    logic        eo  [2];

    initial begin
        lim[0] = 64'h100_0000_0000;
        lim[1] = 64'h1_0000_0000;
    end

    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 2; d++) begin
            if (rst || clear) begin
                hold[d] <= 0;
                tot[d]  <= 0;
                n[d]    <= 0;
                ev[d]   <= 0;
            end else if (!hold[d]) begin
                if (in_valid) begin
                    if (n[d] == 3) begin
                        ev[d]   <= 1;
                        et[d]   <= (tot[d] + 64'(in_sum)) % lim[d];
                        eo[d]   <= (tot[d] + 64'(in_sum)) >= lim[d];
                        hold[d] <= 1;
                        tot[d]  <= 0;
                        n[d]    <= 0;
                    end else begin
                        tot[d] <= tot[d] + 64'(in_sum);
                        n[d]   <= n[d] + 1;
                    end
                end
            end else if (out_ready) begin
                ev[d]   <= 0;
                hold[d] <= 0;
            end
            if (rst) begin
                et[d] <= 0;
                eo[d] <= 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("g8_in_ready", 64'(bi.in_ready), 64'(!rst && !hold[0] && !clear));
        chk("g0_in_ready", 64'(bz.in_ready), 64'(!rst && !hold[1] && !clear));
        chk("g8_out_valid", 64'(bi.out_valid), 64'(ev[0]));
        chk("g0_out_valid", 64'(bz.out_valid), 64'(ev[1]));
        if (ev[0]) begin
            chk("g8_out_total", 64'(bi.out_total), et[0]);
            chk("g8_out_overflow", 64'(bi.out_overflow), 64'(eo[0]));
        end
        if (ev[1]) begin
            chk("g0_out_total", 64'(bz.out_total), et[1]);
            chk("g0_out_overflow", 64'(bz.out_overflow), 64'(eo[1]));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beats(input logic [31:0] v, input int k);
        for (int i = 0; i < k; i++) begin
            in_valid = 1;
            in_sum   = v;
            cyc();
        end
        in_valid = 0;
    endtask

    initial begin
        #1;
        chk("rst_out_valid", 64'(bi.out_valid), 64'd0);
        chk("rst_out_total", 64'(bi.out_total), 64'd0);
        chk("rst_out_overflow", 64'(bi.out_overflow), 64'd0);
        chk("rst_in_ready", 64'(bi.in_ready), 64'd0);
        cyc();
        cyc();
        rst = 0;
        cyc();
        chk("post_rst_in_ready", 64'(bi.in_ready), 64'd1);

        for (int i = 1; i <= 4; i++) begin
            in_valid = 1;
            in_sum   = 32'(i);
            cyc();
        end
        in_valid = 0;
        chk("b1234_valid", 64'(bi.out_valid), 64'd1);
        chk("b1234_total", 64'(bi.out_total), 64'd10);
        chk("b1234_ovf", 64'(bi.out_overflow), 64'd0);
        chk("b1234_in_ready_hold", 64'(bi.in_ready), 64'd0);
        cyc();
        chk("b1234_in_ready_next", 64'(bi.in_ready), 64'd1);

        beats(32'hFFFF_FFFF, 4);
        chk("max_total", 64'(bi.out_total), 64'h3_FFFF_FFFC);
        chk("max_ovf", 64'(bi.out_overflow), 64'd0);
        cyc();

        beats(32'hFFFF_FFFF, 1);
        beats(32'd1, 1);
        beats(32'd0, 2);
        chk("g0_wrap_total", 64'(bz.out_total), 64'd0);
        chk("g0_wrap_ovf", 64'(bz.out_overflow), 64'd1);
        chk("g8_wrap_total", 64'(bi.out_total), 64'h1_0000_0000);
        cyc();

        out_ready = 0;
        beats(32'd1, 4);
        in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_total", 64'(bi.out_total), 64'd4);
            chk("bp_in_ready", 64'(bi.in_ready), 64'd0);
            chk("bp_valid", 64'(bi.out_valid), 64'd1);
            cyc();
        end
        out_ready = 1;
        cyc();
        beats(32'd1, 4);
        chk("bp_next_block", 64'(bi.out_total), 64'd4);
        cyc();

        beats(32'd5, 1);
        beats(32'd7, 1);
        clear    = 1;
        in_valid = 1;
        in_sum   = 32'd100;
        cyc();
        clear = 0;
        beats(32'd1, 4);
        chk("clear_total", 64'(bi.out_total), 64'd4);
        cyc();

        beats(32'd9, 2);
        rst = 1;
        #1;
        chk("rst_mid_in_ready", 64'(bi.in_ready), 64'd0);
        cyc();
        rst = 0;
        beats(32'd2, 4);
        chk("rst_mid_total", 64'(bi.out_total), 64'd8);
        cyc();

        out_ready = 0;
        beats(32'd2, 4);
        chk("hold_valid", 64'(bi.out_valid), 64'd1);
        rst = 1;
        #1;
        chk("rst_hold_valid", 64'(bi.out_valid), 64'd0);
        cyc();
        rst       = 0;
        out_ready = 1;
        beats(32'd2, 4);
        chk("rst_hold_total", 64'(bi.out_total), 64'd8);
        cyc();

        for (int i = 0; i < 3000; i++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            in_sum    = $urandom_range(0, 1) ? 32'($urandom) : 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
            out_ready = $urandom_range(0, 2) != 0;
            clear     = $urandom_range(0, 40) == 0;
            rst       = $urandom_range(0, 150) == 0;
            cyc();
        end
        rst   = 0;
        clear = 0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
